// File: rtl/accum_drain.sv
// Drains a tile of rows from the skewed accumulator, deskews the bank data into rows and streams them out through a small FIFO.
// Build option ACC_DRAIN_RELU_EN clamps negative output words to zero at the FIFO read port.
module accum_drain #(
   parameter int MUL_SIZE   = 32,
   parameter int RES_WIDTH  = 31,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                start_i,
   input  logic [9:0]                          base_addr_i,
   input  logic [9:0]                          rows_i,
   output logic                                busy_o,
   output logic                                done_o,
   output logic                                acc_rd_en_o,
   output logic [9:0]                          acc_addr_rd_o,
   output logic [MUL_SIZE-1:0]                 acc_rd_mask_o,
   input  logic [MUL_SIZE*(RES_WIDTH+1)-1:0]   acc_data_i,
   output logic                                out_valid_o,
   input  logic                                out_ready_i,
   output logic [MUL_SIZE*(RES_WIDTH+1)-1:0]   out_data_o,
   output logic                                out_last_o
);
   localparam int W  = RES_WIDTH + 1;
   localparam int RW = MUL_SIZE * W;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

   state_t              state, state_nxt;
   logic [10:0]         step, step_last;
   logic [9:0]          base, rows;
   logic                issue, room_ok, pop;
   int                  room;
   logic [MUL_SIZE-1:0] mask, beat_mask;
   logic                beat, beat_row, beat_last;
   logic                row_vld, row_last, last_wr;
   logic [RW-1:0]       row_dat;
   logic [RW:0]         mem [FIFO_DEPTH];
   logic [RW:0]         head;
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [CW-1:0]       count;

   assign step_last = {1'b0, rows} + 11'(MUL_SIZE - 2);
   assign pop       = (count != '0) && out_ready_i;

   // Rows already issued but not yet written still need a FIFO slot; an entry popped this cycle counts as free.
   always_comb begin
      room    = FIFO_DEPTH - int'(count) + int'(pop) - int'(beat_row) - int'(row_vld);
      room_ok = (room >= 2);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) state_nxt = (rows_i == '0) ? DONE : DRAIN;
         end
         DRAIN: begin
            busy_o = 1'b1;
            issue  = room_ok;
            if (room_ok && step == step_last) state_nxt = FLUSH;
         end
         FLUSH: begin
            busy_o = 1'b1;
            if (last_wr && count == '0) state_nxt = DONE;
         end
         DONE: begin
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign acc_rd_en_o = issue;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         step <= '0;
         base <= '0;
         rows <= '0;
      end else if (state == IDLE && start_i) begin
         step <= '0;
         base <= base_addr_i;
         rows <= rows_i;
      end else if (issue) begin
         step <= step + 11'd1;
      end
   end

   always_comb begin
      acc_addr_rd_o = '0;
      mask          = '0;
      if (state == DRAIN) begin
         acc_addr_rd_o = (step < {1'b0, rows}) ? base + step[9:0] : base + rows - 10'd1;
         for (int j = 0; j < MUL_SIZE; j++)
            if (step >= 11'(j) && (step - 11'(j)) < {1'b0, rows}) mask[MUL_SIZE-1-j] = 1'b1;
      end
   end

   assign acc_rd_mask_o = mask;

   // beat: acc_data_i carries the reply to the previous issue; a row is aligned once step MUL_SIZE-1 of it has landed.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         beat      <= 1'b0;
         beat_mask <= '0;
         beat_row  <= 1'b0;
         beat_last <= 1'b0;
         row_vld   <= 1'b0;
         row_last  <= 1'b0;
         last_wr   <= 1'b0;
      end else begin
         beat      <= issue;
         beat_mask <= mask;
         beat_row  <= issue && (step >= 11'(MUL_SIZE - 1));
         beat_last <= issue && (step == step_last);
         row_vld   <= beat_row;
         row_last  <= beat_last;
         if (state == DONE)          last_wr <= 1'b0;
         else if (row_vld && row_last) last_wr <= 1'b1;
      end
   end

   for (genvar j = 0; j < MUL_SIZE; j++) begin : g_col
      localparam int LEN = MUL_SIZE - j;
      logic [W-1:0] tap [LEN];

      always_ff @(posedge clk_i or negedge rst_i) begin
         if (!rst_i) begin
            for (int i = 0; i < LEN; i++) tap[i] <= '0;
         end else if (beat) begin
            if (beat_mask[MUL_SIZE-1-j]) tap[0] <= acc_data_i[j*W +: W];
            for (int i = 1; i < LEN; i++) tap[i] <= tap[i-1];
         end
      end

      assign row_dat[j*W +: W] = tap[LEN-1];
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (row_vld) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)     rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({row_vld, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (row_vld) mem[wr_ptr] <= {row_last, row_dat};
   end

   assign head        = mem[rd_ptr];
   assign out_valid_o = (count != '0);
   assign out_last_o  = out_valid_o & head[RW];

   always_comb begin
      out_data_o = '0;
      if (out_valid_o) begin
         for (int j = 0; j < MUL_SIZE; j++) begin
            out_data_o[j*W +: W] = head[j*W +: W];
`ifdef ACC_DRAIN_RELU_EN
            if (head[j*W + W - 1]) out_data_o[j*W +: W] = '0;
`endif
         end
      end
   end

endmodule
